data_memory_ctrl: RTL and testbench

//  Parametrised successor to the CPU data memory. Word-addressed synchronous RAM

---
 rtl/data_memory_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Word-addressed synchronous data RAM for the CPU load/store stage. Each
//   access goes through a request/Ready handshake and takes a programmable
//   number of wait states. Writes honour per-byte lane enables. Out-of-range
//   addresses and illegal read+write requests complete with an error flag.
//
// Handshake: a request is MemRead|MemWrite seen at a rising edge while the
//   controller can accept (Busy low, or in the final Ready cycle). Inputs are
//   sampled only at that acceptance edge. The access then completes with a
//   single-cycle Ready pulse. Requests seen at other times are dropped, not
//   queued. The CPU must hold off while Busy is high.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   synchronous reset, active-low
//   Adresa    in   word address, sampled at acceptance
//   WriteData in   write data, sampled at acceptance
//   ByteEn    in   byte-lane write enables (bit i covers [8i+7:8i])
//   MemWrite  in   write request
//   MemRead   in   read request
//   ReadData  out  registered read data, held until the next good read
//   Ready     out  one-cycle completion pulse
//   AddrErr   out  error pulse, only ever high together with Ready
//   Busy      out  access in progress
//   DbgState  out  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   Adresa,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [DATA_W-1:0]   ReadData,
  output logic                Ready,
  output logic                AddrErr,
  output logic                Busy,
  output logic [1:0]          DbgState
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_rd;
  logic              r_wr;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_req;
  logic w_accept;
  logic w_complete;
  logic w_addr_bad;

  assign w_req = MemRead | MemWrite;

  // The Ready cycle (DONE) also accepts, so back-to-back requests can be
  // spaced WAIT_STATES+2 cycles apart.
  assign w_accept = w_req && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Completion edge: the last WAIT cycle. With zero wait states WAIT still
  // lasts one cycle, which is the RAM access cycle itself.
  assign w_complete = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // Full-width compare: addresses above DEPTH never alias onto the RAM.
  assign w_addr_bad = ({1'b0, Adresa} >= DEPTH_X);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (w_complete) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_WAIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- request latches
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= WAIT_INIT;
      r_idx   <= Adresa[IDX_W-1:0];
      r_wdata <= WriteData;
      r_be    <= ByteEn;
      r_rd    <= MemRead;
      r_wr    <= MemWrite;
      // Error is decided up front so completion only has to consult one bit.
      r_err   <= w_addr_bad | (MemRead & MemWrite);
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ------------------------------------------------------------ read data
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ReadData <= '0;
    end else if (w_complete && r_rd && !r_err) begin
      ReadData <= r_mem[r_idx];
    end
  end

  // ----------------------------------------------------------------- RAM
  // Not reset. A reset at the completion edge suppresses the commit.
  always_ff @(posedge Clock) begin
    if (Reset && w_complete && r_wr && !r_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign Ready    = (r_state == S_DONE);
  assign AddrErr  = (r_state == S_DONE) && r_err;
  assign Busy     = (r_state != S_IDLE);
  assign DbgState = r_state;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl. Three instances share one clock:
//   index 0 : WAIT_STATES=1, index 1 : WAIT_STATES=3, index 2 : WAIT_STATES=0
module tb_data_memory_ctrl;

  logic        clk;
  logic        rst  [3];
  logic [15:0] adr  [3];
  logic [15:0] wd   [3];
  logic [1:0]  be   [3];
  logic        mw   [3];
  logic        mr   [3];
  logic [15:0] rdd  [3];
  logic        rdy  [3];
  logic        aerr [3];
  logic        bsy  [3];
  logic [1:0]  dst  [3];

  int n_total = 0;
  int n_pass  = 0;

  // ------------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(1)) dut_w1 (
    .Clock(clk), .Reset(rst[0]), .Adresa(adr[0]), .WriteData(wd[0]), .ByteEn(be[0]),
    .MemWrite(mw[0]), .MemRead(mr[0]), .ReadData(rdd[0]), .Ready(rdy[0]),
    .AddrErr(aerr[0]), .Busy(bsy[0]), .DbgState(dst[0]));

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(3)) dut_w3 (
    .Clock(clk), .Reset(rst[1]), .Adresa(adr[1]), .WriteData(wd[1]), .ByteEn(be[1]),
    .MemWrite(mw[1]), .MemRead(mr[1]), .ReadData(rdd[1]), .Ready(rdy[1]),
    .AddrErr(aerr[1]), .Busy(bsy[1]), .DbgState(dst[1]));

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) dut_w0 (
    .Clock(clk), .Reset(rst[2]), .Adresa(adr[2]), .WriteData(wd[2]), .ByteEn(be[2]),
    .MemWrite(mw[2]), .MemRead(mr[2]), .ReadData(rdd[2]), .Ready(rdy[2]),
    .AddrErr(aerr[2]), .Busy(bsy[2]), .DbgState(dst[2]));

  // ---------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ------------------------------------------------------------- drivers
  task automatic drive(input int k, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    mr[k]  = rd;
    mw[k]  = wr;
    adr[k] = a;
    wd[k]  = d;
    be[k]  = b;
  endtask

  // One request: returns edges from acceptance to the Ready edge, and AddrErr
  // as seen in the Ready cycle. A missing Ready yields lat=40.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d, input logic [1:0] b,
                        output int lat, output logic e);
    @(negedge clk);
    drive(k, rd, wr, a, d, b);
    @(posedge clk);
    #1;
    drive(k, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    lat = 0;
    e   = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdy[k]) break;
    end
    e = aerr[k];
  endtask

  // Count Ready pulses of instance k over n cycles.
  task automatic count_ready(input int k, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rdy[k]) cnt++;
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin : main
    int   lat;
    logic e;
    int   cnt;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      drive(k, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset rdata %0d", k), 32'(rdd[k]), 32'h0);
      chk($sformatf("reset ready %0d", k), 32'(rdy[k]), 32'h0);
      chk($sformatf("reset busy %0d", k),  32'(bsy[k]), 32'h0);
      chk($sformatf("reset state %0d", k), 32'(dst[k]), 32'h0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;

    // 1. write then read addr 2 (W=1)
    access(0, 1'b0, 1'b1, 16'd2, 16'h0012, 2'b11, lat, e);
    chk("t1 wr lat", 32'(lat), 32'd2);
    chk("t1 wr err", 32'(e), 32'h0);
    access(0, 1'b1, 1'b0, 16'd2, 16'h0, 2'b00, lat, e);
    chk("t1 rd lat", 32'(lat), 32'd2);
    chk("t1 rd err", 32'(e), 32'h0);
    chk("t1 rdata", 32'(rdd[0]), 32'h0012);

    // 2. partial byte write
    access(0, 1'b0, 1'b1, 16'd4, 16'h1234, 2'b11, lat, e);
    access(0, 1'b0, 1'b1, 16'd4, 16'hABCD, 2'b01, lat, e);
    access(0, 1'b1, 1'b0, 16'd4, 16'h0, 2'b00, lat, e);
    chk("t2 rdata", 32'(rdd[0]), 32'h12CD);

    // ByteEn=0 completes without touching the word
    access(0, 1'b0, 1'b1, 16'd2, 16'hFFFF, 2'b00, lat, e);
    chk("be0 lat", 32'(lat), 32'd2);
    chk("be0 err", 32'(e), 32'h0);

    // 3. errors: out of range, top legal address, read+write
    access(0, 1'b1, 1'b0, 16'd300, 16'h0, 2'b00, lat, e);
    chk("t3 oor lat", 32'(lat), 32'd2);
    chk("t3 oor err", 32'(e), 32'h1);
    chk("t3 oor rdata", 32'(rdd[0]), 32'h12CD);
    access(0, 1'b1, 1'b0, 16'd256, 16'h0, 2'b00, lat, e);
    chk("t3 256 err", 32'(e), 32'h1);
    access(0, 1'b0, 1'b1, 16'd255, 16'hBEEF, 2'b11, lat, e);
    chk("t3 255 wr err", 32'(e), 32'h0);
    access(0, 1'b1, 1'b0, 16'd255, 16'h0, 2'b00, lat, e);
    chk("t3 255 rdata", 32'(rdd[0]), 32'hBEEF);
    access(0, 1'b1, 1'b1, 16'd2, 16'h7777, 2'b11, lat, e);
    chk("t3 both err", 32'(e), 32'h1);
    chk("t3 both rdata", 32'(rdd[0]), 32'hBEEF);
    access(0, 1'b0, 1'b1, 16'd44, 16'h4444, 2'b11, lat, e);
    access(0, 1'b0, 1'b1, 16'd300, 16'h9999, 2'b11, lat, e);
    chk("t3 wr300 err", 32'(e), 32'h1);
    access(0, 1'b1, 1'b0, 16'd44, 16'h0, 2'b00, lat, e);
    chk("t3 no alias", 32'(rdd[0]), 32'h4444);
    access(0, 1'b1, 1'b0, 16'd2, 16'h0, 2'b00, lat, e);
    chk("t3 addr2 kept", 32'(rdd[0]), 32'h0012);

    // 4. request while busy is ignored
    access(0, 1'b0, 1'b1, 16'd8, 16'h0808, 2'b11, lat, e);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'd7, 16'h0707, 2'b11);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 16'd8, 16'h5555, 2'b11);
    chk("t4 busy", 32'(bsy[0]), 32'h1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    count_ready(0, 6, cnt);
    chk("t4 ready count", 32'(cnt), 32'd1);
    access(0, 1'b1, 1'b0, 16'd8, 16'h0, 2'b00, lat, e);
    chk("t4 addr8", 32'(rdd[0]), 32'h0808);
    access(0, 1'b1, 1'b0, 16'd7, 16'h0, 2'b00, lat, e);
    chk("t4 addr7", 32'(rdd[0]), 32'h0707);

    // 5. reset aborts an in-flight write (W=3)
    access(1, 1'b0, 1'b1, 16'd5, 16'h0001, 2'b11, lat, e);
    chk("t5 wr lat", 32'(lat), 32'd4);
    access(1, 1'b1, 1'b0, 16'd5, 16'h0, 2'b00, lat, e);
    chk("t5 pre rdata", 32'(rdd[1]), 32'h0001);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 16'd5, 16'hFFFF, 2'b11);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    chk("t5 rst ready", 32'(rdy[1]), 32'h0);
    chk("t5 rst busy", 32'(bsy[1]), 32'h0);
    chk("t5 rst err", 32'(aerr[1]), 32'h0);
    chk("t5 rst rdata", 32'(rdd[1]), 32'h0);
    chk("t5 rst state", 32'(dst[1]), 32'h0);
    count_ready(1, 6, cnt);
    chk("t5 no ready", 32'(cnt), 32'd0);
    access(1, 1'b1, 1'b0, 16'd5, 16'h0, 2'b00, lat, e);
    chk("t5 post rdata", 32'(rdd[1]), 32'h0001);

    // 6. back-to-back reads with W=0
    access(2, 1'b0, 1'b1, 16'd2, 16'h2222, 2'b11, lat, e);
    chk("t6 wr lat", 32'(lat), 32'd1);
    access(2, 1'b0, 1'b1, 16'd4, 16'h4444, 2'b11, lat, e);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 16'd2, 16'h0, 2'b00);
    @(posedge clk);
    #1;
    drive(2, 1'b1, 1'b0, 16'd4, 16'h0, 2'b00);
    chk("t6 a0 busy", 32'(bsy[2]), 32'h1);
    chk("t6 a0 ready", 32'(rdy[2]), 32'h0);
    @(posedge clk);
    #1;
    chk("t6 r0 ready", 32'(rdy[2]), 32'h1);
    chk("t6 r0 rdata", 32'(rdd[2]), 32'h2222);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    chk("t6 a1 ready", 32'(rdy[2]), 32'h0);
    chk("t6 a1 state", 32'(dst[2]), 32'h1);
    @(posedge clk);
    #1;
    chk("t6 r1 ready", 32'(rdy[2]), 32'h1);
    chk("t6 r1 rdata", 32'(rdd[2]), 32'h4444);
    @(posedge clk);
    #1;
    chk("t6 idle busy", 32'(bsy[2]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
